b11_req_sched: RTL

- Round-robin scheduler that shares one b11-style character-transform engine (6-bit x_in/stbi in, 6-bit x_out out) between four requesters.
- Arbitrates, presents the winner's 6-bit symbol to the engine with a stbi strobe, and waits for the engine's done pulse or a timeout.
- Returns the result tagged with the requester ID.
- Sits between the client ports and the engine instance.

---
 rtl/b11_req_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/b11_req_sched.sv
// ---------------------------------------------------------------------------
// b11_req_sched
//   Round-robin scheduler that shares one b11-style character-transform
//   engine between four requesters. It arbitrates among pending requests,
//   presents the winner's 6-bit symbol to the engine with a strobe, and
//   waits for the engine's done pulse or a timeout. It then returns the
//   result tagged with the requester ID.
//
// Parameters
//   NREQ     number of requesters (fixed at 4; pointer and ID are 2 bits)
//   STB_CYC  cycles eng_stbi is held high per transaction (1..15)
//   TIMEOUT  maximum WAIT cycles before an error response (2..255)
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req        in   per-requester request level, held until matching gnt
//   req_data   in   symbols, requester i uses bits [6i+5:6i]
//   gnt        out  one-hot, one-cycle grant pulse
//   eng_x_in   out  symbol to engine (0 while idle)
//   eng_stbi   out  engine strobe
//   eng_x_out  in   engine result, valid while eng_done is high
//   eng_done   in   one-cycle engine completion pulse
//   rsp_valid  out  one-cycle response pulse
//   rsp_id     out  requester ID of the response
//   rsp_data   out  result (0 on timeout), held until the next response
//   rsp_err    out  set with rsp_valid when the transaction timed out
//   busy       out  high in every state except IDLE
// ---------------------------------------------------------------------------
module b11_req_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned STB_CYC = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [6*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic [5:0]          eng_x_in,
  output logic                eng_stbi,
  input  logic [5:0]          eng_x_out,
  input  logic                eng_done,
  output logic                rsp_valid,
  output logic [1:0]          rsp_id,
  output logic [5:0]          rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESP
  } state_t;

  // State and bookkeeping registers
  state_t          r_state,     w_state_nxt;
  logic [1:0]      r_rr_ptr,    w_rr_ptr_nxt;
  logic [7:0]      r_cnt,       w_cnt_nxt;
  logic [1:0]      r_id,        w_id_nxt;

  // Registered outputs
  logic [NREQ-1:0] r_gnt,       w_gnt_nxt;
  logic [5:0]      r_x_in,      w_x_in_nxt;
  logic            r_stbi,      w_stbi_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]      r_rsp_id,    w_rsp_id_nxt;
  logic [5:0]      r_rsp_data,  w_rsp_data_nxt;
  logic            r_rsp_err,   w_rsp_err_nxt;
  logic            r_busy,      w_busy_nxt;

  // Arbiter results
  logic            w_arb_hit;
  logic [1:0]      w_arb_id;
  logic [1:0]      w_arb_idx;

  // Round-robin pick: first set request scanning rr_ptr, rr_ptr+1, ...
  // The 2-bit index wraps naturally modulo 4.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_id  = '0;
    w_arb_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_arb_idx = r_rr_ptr + 2'(k);
      if (!w_arb_hit && req[w_arb_idx]) begin
        w_arb_hit = 1'b1;
        w_arb_id  = w_arb_idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_cnt_nxt       = r_cnt;
    w_id_nxt        = r_id;
    w_gnt_nxt       = '0;
    w_x_in_nxt      = r_x_in;
    w_stbi_nxt      = r_stbi;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      S_IDLE: begin
        if (w_arb_hit) begin
          w_id_nxt            = w_arb_id;
          w_gnt_nxt[w_arb_id] = 1'b1;
          w_x_in_nxt          = req_data[6*w_arb_id +: 6];
          w_stbi_nxt          = 1'b1;
          w_cnt_nxt           = '0;
          w_busy_nxt          = 1'b1;
          w_state_nxt         = S_LOAD;
        end
      end

      // The first LOAD cycle counts toward STB_CYC; eng_done is ignored here.
      S_LOAD: begin
        if (r_cnt == 8'(STB_CYC - 1)) begin
          w_stbi_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      // eng_done is tested before the timeout so a coincident done wins.
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (eng_done) begin
          w_rsp_data_nxt  = eng_x_out;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_id;
          w_x_in_nxt      = '0;
          w_state_nxt     = S_RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_rsp_data_nxt  = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_id;
          w_x_in_nxt      = '0;
          w_state_nxt     = S_RESP;
        end
      end

      // The served ID becomes lowest priority for the next arbitration.
      S_RESP: begin
        w_rr_ptr_nxt = r_id + 2'd1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_gnt       <= '0;
      r_x_in      <= '0;
      r_stbi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_id        <= w_id_nxt;
      r_gnt       <= w_gnt_nxt;
      r_x_in      <= w_x_in_nxt;
      r_stbi      <= w_stbi_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign eng_x_in  = r_x_in;
  assign eng_stbi  = r_stbi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule
